conv_window_gen: RTL and testbench

- Builds 3x3 convolution windows from a raster-order 8-bit pixel stream using two internal line buffers.
- Emits nine pixels per window as one flat bus. This bus feeds the per-channel input skew stage of the conv unit.
- Valid-convolution only, no padding. One window per accepted pixel once the kernel fits inside the image.

---
 rtl/conv_window_gen_pkg.sv | 24 ++
 rtl/conv_line_buffer.sv | 23 ++
 rtl/conv_window_gen.sv | 133 +++++++++++++
 tb/tb_conv_window_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_gen_pkg.sv
// Shared constants, pixel/column types and window indexing for the 3x3 window generator.
package conv_window_gen_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned KERNEL     = 3;
  localparam int unsigned MAX_IMG_W  = 64;
  localparam int unsigned W_BITS     = $clog2(MAX_IMG_W);
  localparam int unsigned WIN_WIDTH  = KERNEL * KERNEL * DATA_WIDTH;

  typedef logic [DATA_WIDTH-1:0] pixel_t;

  // One vertical slice of the window as it enters the rightmost column
  typedef struct packed {
    pixel_t top;
    pixel_t mid;
    pixel_t bot;
  } col_vec_t;

  // Flat element index of window position (r,c); r=0 top row, c=0 leftmost column
  function automatic int unsigned idx(input int unsigned r, input int unsigned c);
    return r * KERNEL + c;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image-line store: combinational read and clocked write at the same column address.
module conv_line_buffer
  import conv_window_gen_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [W_BITS-1:0] addr,
  input  pixel_t            wr_data,
  output pixel_t            rd_data_c
);

  pixel_t mem [MAX_IMG_W];

  // Contents need no reset: the first two rows of a frame never form a window
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  assign rd_data_c = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Builds valid-only 3x3 windows from a raster 8-bit pixel stream using two line buffers.
module conv_window_gen
  import conv_window_gen_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [W_BITS-1:0]     cfg_img_w,
  input  logic [W_BITS-1:0]     cfg_img_h,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_pixel,
  output logic                  win_valid,
  output logic [WIN_WIDTH-1:0]  win_data,
  output logic                  frame_done,
  output logic                  busy
);

  logic [W_BITS-1:0]    col_q, col_d;
  logic [W_BITS-1:0]    row_q, row_d;
  logic [W_BITS-1:0]    img_w_q, img_w_d;
  logic [W_BITS-1:0]    img_h_q, img_h_d;
  logic                 busy_d;
  logic                 win_valid_d;
  logic                 frame_done_d;
  logic [WIN_WIDTH-1:0] win_d;

  logic                 accept_c;
  logic [W_BITS-1:0]    eff_w_c;
  logic [W_BITS-1:0]    eff_h_c;
  logic                 last_col_c;
  logic                 last_row_c;
  pixel_t               lb0_rd_c;
  pixel_t               lb1_rd_c;
  col_vec_t             cvec_c;

  // clear takes priority over a pixel presented in the same cycle
  assign accept_c = in_valid & ~clear;

  // The first pixel of a frame decides wrap using the live config, later pixels the shadow copy
  assign eff_w_c    = busy ? img_w_q : cfg_img_w;
  assign eff_h_c    = busy ? img_h_q : cfg_img_h;
  assign last_col_c = (col_q == eff_w_c);
  assign last_row_c = (row_q == eff_h_c);

  // lb0 holds the previous line, lb1 the line before it; lb1 is fed from lb0's old value
  conv_line_buffer u_lb0 (
    .clk      (clk),
    .wr_en    (accept_c),
    .addr     (col_q),
    .wr_data  (in_pixel),
    .rd_data_c(lb0_rd_c)
  );

  conv_line_buffer u_lb1 (
    .clk      (clk),
    .wr_en    (accept_c),
    .addr     (col_q),
    .wr_data  (lb0_rd_c),
    .rd_data_c(lb1_rd_c)
  );

  assign cvec_c = '{top: lb1_rd_c, mid: lb0_rd_c, bot: in_pixel};

  // Next-state: counters, config shadow, window shift and output strobes
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    img_w_d      = img_w_q;
    img_h_d      = img_h_q;
    busy_d       = busy;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    win_d        = win_data;

    if (clear) begin
      col_d  = '0;
      row_d  = '0;
      busy_d = 1'b0;
    end else if (accept_c) begin
      if (!busy) begin
        img_w_d = cfg_img_w;
        img_h_d = cfg_img_h;
      end
      busy_d      = 1'b1;
      win_valid_d = (row_q >= W_BITS'(2)) && (col_q >= W_BITS'(2));

      if (last_col_c) begin
        col_d = '0;
        if (last_row_c) begin
          row_d        = '0;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + W_BITS'(1);
        end
      end else begin
        col_d = col_q + W_BITS'(1);
      end

      for (int unsigned r = 0; r < KERNEL; r++) begin
        for (int unsigned c = 0; c < KERNEL - 1; c++) begin
          win_d[idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = win_data[idx(r, c + 1)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      win_d[idx(0, KERNEL - 1)*DATA_WIDTH +: DATA_WIDTH] = cvec_c.top;
      win_d[idx(1, KERNEL - 1)*DATA_WIDTH +: DATA_WIDTH] = cvec_c.mid;
      win_d[idx(2, KERNEL - 1)*DATA_WIDTH +: DATA_WIDTH] = cvec_c.bot;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q      <= '0;
      row_q      <= '0;
      img_w_q    <= '0;
      img_h_q    <= '0;
      busy       <= 1'b0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_data   <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      img_w_q    <= img_w_d;
      img_h_q    <= img_h_d;
      busy       <= busy_d;
      win_valid  <= win_valid_d;
      frame_done <= frame_done_d;
      win_data   <= win_d;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed and randomized frames checked against an array-based window reference model.
module tb_conv_window_gen;
  import conv_window_gen_pkg::*;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [W_BITS-1:0]     cfg_img_w;
  logic [W_BITS-1:0]     cfg_img_h;
  logic                  clear;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_pixel;
  logic                  win_valid;
  logic [WIN_WIDTH-1:0]  win_data;
  logic                  frame_done;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  int win_cnt = 0;
  int done_cnt = 0;
  bit got_first;
  logic [WIN_WIDTH-1:0] first_win;
  logic [7:0] img [4096];

  conv_window_gen dut (
    .clk       (clk),
    .rstn      (rstn),
    .cfg_img_w (cfg_img_w),
    .cfg_img_h (cfg_img_h),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_pixel  (in_pixel),
    .win_valid (win_valid),
    .win_data  (win_data),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference window whose bottom-right pixel is image position (r,c)
  function automatic logic [71:0] ref_win(input int r, input int c, input int w);
    logic [71:0] v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[(i*3+j)*8 +: 8] = img[(r-2+i)*w + (c-2+j)];
    return v;
  endfunction

  task automatic fill_seq(input int n, input int base);
    for (int k = 0; k < n; k++) img[k] = 8'(base + k);
  endtask

  task automatic fill_rand(input int n);
    for (int k = 0; k < n; k++) img[k] = 8'($urandom);
  endtask

  // Present pixel k of a w x h frame, then check the registered response
  task automatic send(input int k, input int w, input int h);
    int  r = k / w;
    int  c = k % w;
    bit  exp_v = (r >= 2) && (c >= 2);
    bit  last = (k == w*h - 1);
    in_valid = 1'b1;
    in_pixel = img[k];
    @(posedge clk); #1;
    check("win_valid", 72'(win_valid), 72'(exp_v));
    if (win_valid) win_cnt++;
    if (frame_done) done_cnt++;
    if (exp_v) begin
      check("win_data", win_data, ref_win(r, c, w));
      if (!got_first) begin
        first_win = win_data;
        got_first = 1'b1;
      end
    end
    check("frame_done", 72'(frame_done), 72'(last));
    check("busy", 72'(busy), 72'(!last));
  endtask

  task automatic idle(input int n);
    logic [WIN_WIDTH-1:0] prev;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      prev = win_data;
      @(posedge clk); #1;
      if (win_valid) win_cnt++;
      if (frame_done) done_cnt++;
      check("gap_win_valid", 72'(win_valid), 72'd0);
      check("gap_frame_done", 72'(frame_done), 72'd0);
      check("gap_win_hold", win_data, prev);
    end
  endtask

  // gap: 0 continuous, 1 alternate, 2 random; chg_w>=0 rewrites cfg_img_w mid-frame
  task automatic run_frame(input int w, input int h, input int gap, input int chg_w);
    int w0 = win_cnt;
    int d0 = done_cnt;
    got_first = 1'b0;
    cfg_img_w = W_BITS'(w - 1);
    cfg_img_h = W_BITS'(h - 1);
    for (int k = 0; k < w*h; k++) begin
      if (chg_w >= 0 && k == 5) cfg_img_w = W_BITS'(chg_w);
      send(k, w, h);
      if (gap == 1 || (gap == 2 && $urandom_range(99) < 30)) idle(1);
    end
    check("win_count", 72'(win_cnt - w0), 72'((w-2)*(h-2)));
    check("done_count", 72'(done_cnt - d0), 72'd1);
  endtask

  initial begin
    rstn = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_pixel = '0;
    cfg_img_w = 6'd3;
    cfg_img_h = 6'd3;
    repeat (2) @(posedge clk);
    #1;
    check("rst_win_valid", 72'(win_valid), 72'd0);
    check("rst_win_data", win_data, 72'd0);
    check("rst_busy", 72'(busy), 72'd0);
    check("rst_frame_done", 72'(frame_done), 72'd0);
    rstn = 1'b1;
    idle(1);

    // 4x4 continuous
    fill_seq(16, 0);
    run_frame(4, 4, 0, -1);
    check("first_win_4x4", first_win, 72'h0a0908060504020100);
    idle(2);

    // 4x4 with alternating gaps
    run_frame(4, 4, 1, -1);
    check("first_win_gaps", first_win, 72'h0a0908060504020100);
    idle(1);

    // two back-to-back 3x3 frames
    fill_seq(9, 0);
    run_frame(3, 3, 0, -1);
    check("win_3x3_a", first_win, 72'h080706050403020100);
    fill_seq(9, 100);
    run_frame(3, 3, 0, -1);
    check("win_3x3_b", first_win, 72'h6c6b6a696867666564);
    idle(1);

    // config change mid-frame is ignored; next frame uses width 6
    fill_seq(16, 0);
    run_frame(4, 4, 0, 5);
    fill_seq(24, 40);
    run_frame(6, 4, 0, -1);
    idle(1);

    // clear after pixel 7 with a simultaneous pixel that must be dropped
    fill_seq(16, 200);
    cfg_img_w = 6'd3;
    cfg_img_h = 6'd3;
    for (int k = 0; k < 8; k++) send(k, 4, 4);
    clear = 1'b1;
    in_valid = 1'b1;
    in_pixel = 8'd99;
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    check("clr_busy", 72'(busy), 72'd0);
    check("clr_win_valid", 72'(win_valid), 72'd0);
    check("clr_frame_done", 72'(frame_done), 72'd0);
    fill_seq(16, 20);
    run_frame(4, 4, 0, -1);
    check("first_win_clear", first_win, 72'h1e1d1c1a1918161514);
    idle(1);

    // asynchronous reset mid-frame
    fill_seq(16, 0);
    for (int k = 0; k < 11; k++) send(k, 4, 4);
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check("mid_rst_win_valid", 72'(win_valid), 72'd0);
    check("mid_rst_busy", 72'(busy), 72'd0);
    check("mid_rst_win_data", win_data, 72'd0);
    check("mid_rst_frame_done", 72'(frame_done), 72'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(1);
    run_frame(4, 4, 0, -1);
    check("first_win_after_rst", first_win, 72'h0a0908060504020100);
    idle(1);

    // widest legal line
    fill_rand(64*3);
    run_frame(64, 3, 0, -1);
    idle(1);

    // randomized sizes, contents and gaps
    for (int t = 0; t < 6; t++) begin
      int w = $urandom_range(10, 3);
      int h = $urandom_range(6, 3);
      fill_rand(w*h);
      run_frame(w, h, 2, -1);
      if ($urandom_range(1) == 1) idle(1);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
